// File: rtl/param_reg_if.sv
// param_reg_if: data bus of the param_reg retiming register.
//   d_in  : W-bit word sampled by the register on every rising clock edge
//   d_out : W-bit word driven from the last register stage
// The master modport belongs to whoever supplies d_in and observes d_out.
// The slave modport belongs to the register itself.
interface param_reg_if #(
  parameter int unsigned W = 8
);
  logic [W-1:0] d_in;
  logic [W-1:0] d_out;

  modport master (output d_in, input  d_out);
  modport slave  (input  d_in, output d_out);
endinterface

// File: rtl/param_reg.sv
// param_reg: W-bit register chain that delays a bus by DEPTH whole clock cycles.
// Parameters:
//   W       : data width in bits (W >= 1)
//   DEPTH   : number of register stages, which is also the latency in cycles (DEPTH >= 1)
//   RST_VAL : value held in every stage while reset is asserted
// Ports:
//   clk    : clock; all stages update on its rising edge
//   resetn : asynchronous reset. It is active-high despite its name: 1 means reset.
//   bus    : slave side of param_reg_if. bus.d_in is the input and bus.d_out is the output.
// There is no enable. While reset is low, every stage shifts on every edge.
// d_out comes straight from the last stage, so there is no combinational path from d_in.
module param_reg #(
  parameter int unsigned   W       = 8,
  parameter int unsigned   DEPTH   = 1,
  parameter logic [W-1:0]  RST_VAL = '0
) (
  input  logic        clk,
  input  logic        resetn,
  param_reg_if.slave  bus
);

  // stage_q[0] is the newest word and stage_q[DEPTH-1] is the output stage.
  logic [DEPTH-1:0][W-1:0] stage_q;
  logic [DEPTH-1:0][W-1:0] stage_d;

  // Next-state logic: shift the chain by one stage. d_in enters at stage 0.
  if (DEPTH > 1) begin : g_chain
    always_comb begin
      stage_d = {stage_q[DEPTH-2:0], bus.d_in};
    end
  end else begin : g_single
    always_comb begin
      stage_d = bus.d_in;
    end
  end

  // Stage registers. Reset loads RST_VAL as soon as resetn rises, without waiting for a clock edge.
  // An edge that arrives while resetn is still high captures nothing.
  always_ff @(posedge clk or posedge resetn) begin
    if (resetn) begin
      stage_q <= {DEPTH{RST_VAL}};
    end else begin
      stage_q <= stage_d;
    end
  end

  assign bus.d_out = stage_q[DEPTH-1];

endmodule

// File: tb/tb_param_reg.sv
// tb_param_reg: directed bench for param_reg. It uses four instances:
//   u0 : W=8,  DEPTH=1, RST_VAL=0x00
//   u1 : W=8,  DEPTH=3, RST_VAL=0xFF
//   u2 : W=1,  DEPTH=1
//   u3 : W=32, DEPTH=2, RST_VAL=0xDEADBEEF
// Inputs change 1 ns after a rising edge. Outputs are sampled at that same point.
module tb_param_reg;

  logic clk = 1'b0;
  logic resetn;

  always #5 clk = ~clk;

  param_reg_if #(.W(8))  if0 ();
  param_reg_if #(.W(8))  if1 ();
  param_reg_if #(.W(1))  if2 ();
  param_reg_if #(.W(32)) if3 ();

  param_reg #(.W(8),  .DEPTH(1), .RST_VAL(8'h00))
    u0 (.clk(clk), .resetn(resetn), .bus(if0.slave));
  param_reg #(.W(8),  .DEPTH(3), .RST_VAL(8'hFF))
    u1 (.clk(clk), .resetn(resetn), .bus(if1.slave));
  param_reg #(.W(1),  .DEPTH(1), .RST_VAL(1'b0))
    u2 (.clk(clk), .resetn(resetn), .bus(if2.slave));
  param_reg #(.W(32), .DEPTH(2), .RST_VAL(32'hDEADBEEF))
    u3 (.clk(clk), .resetn(resetn), .bus(if3.slave));

  int checks   = 0;
  int failures = 0;

  // History of the words driven to the 8-bit instances. h[0] is the most recent word.
  logic [7:0] h [3];

  typedef struct {
    logic [7:0] din;
    logic [7:0] e0;   // expected u0.d_out after the edge
    logic [7:0] e1;   // expected u1.d_out after the edge
  } vec_t;

  vec_t tbl [4];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic drive(input logic [7:0] v);
    if0.d_in = v;
    if1.d_in = v;
    if2.d_in = v[0];
    if3.d_in = {4{v}};
  endtask

  task automatic push(input logic [7:0] v);
    h[2] = h[1];
    h[1] = h[0];
    h[0] = v;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    logic [7:0]  v;
    logic [31:0] w;
    logic [31:0] prev;

    tbl[0] = '{din: 8'h24, e0: 8'h24, e1: 8'hFF};
    tbl[1] = '{din: 8'h81, e0: 8'h81, e1: 8'hFF};
    tbl[2] = '{din: 8'h09, e0: 8'h09, e1: 8'h24};
    tbl[3] = '{din: 8'h63, e0: 8'h63, e1: 8'h81};

    h[0] = 8'h00;
    h[1] = 8'h00;
    h[2] = 8'h00;
    prev = '0;

    // Hold reset with d_in = 0xA5 for 7 clocks. Every output must stay at its reset value.
    resetn = 1'b1;
    drive(8'hA5);
    for (int i = 0; i < 7; i++) begin
      step();
      chk("rst_u0", 32'(if0.d_out), 32'h00);
      chk("rst_u1", 32'(if1.d_out), 32'hFF);
      chk("rst_u2", 32'(if2.d_out), 32'h0);
      chk("rst_u3", if3.d_out, 32'hDEADBEEF);
    end

    // Release reset between edges, then apply the vector table.
    resetn = 1'b0;
    for (int i = 0; i < 4; i++) begin
      drive(tbl[i].din);
      step();
      push(tbl[i].din);
      chk("tbl_u0", 32'(if0.d_out), 32'(tbl[i].e0));
      chk("tbl_u1", 32'(if1.d_out), 32'(tbl[i].e1));
    end

    // Random stream. u0 shows the word from 1 edge back and u1 the word from 3 edges back.
    for (int i = 0; i < 10; i++) begin
      v = 8'($urandom_range(0, 255));
      drive(v);
      step();
      push(v);
      chk("rnd_u0", 32'(if0.d_out), 32'(h[0]));
      chk("rnd_u1", 32'(if1.d_out), 32'(h[2]));
    end

    // Assert reset 3 ns after an edge. The outputs must change before the next edge.
    drive(8'h63);
    step();
    chk("pre_arst_u0", 32'(if0.d_out), 32'h63);
    #2;
    resetn = 1'b1;
    #1;
    chk("arst_u0", 32'(if0.d_out), 32'h00);
    chk("arst_u1", 32'(if1.d_out), 32'hFF);
    chk("arst_u3", if3.d_out, 32'hDEADBEEF);
    // An edge that arrives while reset is held captures nothing.
    drive(8'h77);
    step();
    chk("rst_edge_u0", 32'(if0.d_out), 32'h00);
    resetn = 1'b0;
    drive(8'h0D);
    step();
    chk("post_rst_u0", 32'(if0.d_out), 32'h0D);
    chk("post_rst_u1", 32'(if1.d_out), 32'hFF);

    // Only the value present at the edge is captured. Earlier values in the same cycle are not.
    drive(8'hAA);
    #4;
    drive(8'h55);
    step();
    chk("mid_cycle_u0", 32'(if0.d_out), 32'h55);

    // Pulse reset again, then run the DEPTH=3 fill sequence.
    resetn = 1'b1;
    #1;
    resetn = 1'b0;
    drive(8'h01); step();
    chk("pipe1_u1", 32'(if1.d_out), 32'hFF);
    chk("pipe1_u0", 32'(if0.d_out), 32'h01);
    drive(8'h02); step();
    chk("pipe2_u1", 32'(if1.d_out), 32'hFF);
    chk("pipe2_u0", 32'(if0.d_out), 32'h02);
    drive(8'h03); step();
    chk("pipe3_u1", 32'(if1.d_out), 32'h01);
    drive(8'h00); step();
    chk("pipe4_u1", 32'(if1.d_out), 32'h02);
    drive(8'h00); step();
    chk("pipe5_u1", 32'(if1.d_out), 32'h03);
    chk("pipe5_u0", 32'(if0.d_out), 32'h00);

    // Walking ones on W=32 (DEPTH=2) and an alternating bit on W=1 (DEPTH=1).
    for (int i = 0; i < 34; i++) begin
      w = (i < 32) ? (32'(1) << i) : 32'h0;
      if3.d_in = w;
      if2.d_in = 1'(i & 1);
      step();
      chk("walk_w1", 32'(if2.d_out), 32'(i & 1));
      if (i >= 1) begin
        chk("walk_w32", if3.d_out, prev);
      end
      prev = w;
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
